alu_seq: RTL and testbench

Sequential, parametrised successor to the combinational add/sub ALU in the cute_processor datapath. It extends the operation set to eight opcodes, including an iterative shift-add multiply. Operands are accepted through a valid/ready input handshake; the result and status flags are held in an output register and released through a valid/ready output handshake. The core's execute stage uses it so that multi-cycle operations can stall the pipeline.

---
 rtl/alu_seq.sv | 153 +++++++++++++++
 tb/tb_alu_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: eight opcodes behind valid/ready handshakes.
// Ops 0-6 complete in one cycle; MUL runs a WORD_SIZE-step shift-add.
module alu_seq #(
    parameter int WORD_SIZE = 8,
    localparam int SHAMT_W = $clog2(WORD_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic [2:0]           op,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_SIZE-1:0] c,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 flag_c,
    output logic                 flag_v,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam int MSB = WORD_SIZE - 1;

    logic [0:0]             state;
    logic [SHAMT_W-1:0]     cnt;
    logic [2*WORD_SIZE-1:0] acc;
    logic [2*WORD_SIZE-1:0] acc_nxt;
    logic [WORD_SIZE-1:0]   ma;
    logic [WORD_SIZE-1:0]   mb;

    logic                   accept;
    logic [SHAMT_W-1:0]     s;
    logic [WORD_SIZE:0]     sum;
    logic [WORD_SIZE:0]     diff;
    logic [WORD_SIZE:0]     shl;
    logic [WORD_SIZE:0]     shr;
    logic [WORD_SIZE-1:0]   res;
    logic                   res_c;
    logic                   res_v;

    assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign s        = b[SHAMT_W-1:0];

    // Single-cycle datapath; shifts use a guard bit to capture the bit shifted out
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        shl   = {1'b0, a} << s;
        shr   = {a, 1'b0} >> s;
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[WORD_SIZE-1:0];
                res_c = sum[WORD_SIZE];
                res_v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                res   = diff[WORD_SIZE-1:0];
                res_c = diff[WORD_SIZE];
                res_v = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: begin
                res   = shl[WORD_SIZE-1:0];
                res_c = shl[WORD_SIZE];
            end
            OP_SHR: begin
                res   = shr[WORD_SIZE:1];
                res_c = shr[0];
            end
            default: ;
        endcase
    end

    // MSB-first shift-add step: double the partial product, add A when the multiplier bit is set
    always_comb begin
        acc_nxt = (acc << 1) + (mb[MSB] ? {{WORD_SIZE{1'b0}}, ma} : '0);
    end

    // Control FSM plus result/flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            c         <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            ma        <= '0;
            mb        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            ma        <= a;
                            mb        <= b;
                            acc       <= '0;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            state     <= MUL;
                        end else begin
                            c         <= res;
                            flag_z    <= (res == '0);
                            flag_n    <= res[MSB];
                            flag_c    <= res_c;
                            flag_v    <= res_v;
                            out_valid <= 1'b1;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    acc <= acc_nxt;
                    mb  <= mb << 1;
                    cnt <= cnt + SHAMT_W'(1);
                    if (cnt == SHAMT_W'(WORD_SIZE - 1)) begin
                        c         <= acc_nxt[WORD_SIZE-1:0];
                        flag_z    <= (acc_nxt[WORD_SIZE-1:0] == '0);
                        flag_n    <= acc_nxt[MSB];
                        flag_c    <= |acc_nxt[2*WORD_SIZE-1:WORD_SIZE];
                        flag_v    <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WORD_SIZE = 8) with hand-computed expectations.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] c;
    logic       flag_z, flag_n, flag_c, flag_v;
    logic       out_valid;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WORD_SIZE(8)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
        .in_valid(in_valid), .in_ready(in_ready),
        .c(c), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flags packed as {z, n, c, v}
    function automatic logic [3:0] flags();
        return {flag_z, flag_n, flag_c, flag_v};
    endfunction

    // Present one operation, confirm it is acceptable, and clock it in
    task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb);
        op = o; a = xa; b = xb; in_valid = 1'b1;
        #1;
        check({tag, "_rdy"}, 16'(in_ready), 16'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [7:0] ec, input logic [3:0] ef);
        check({tag, "_vld"}, 16'(out_valid), 16'd1);
        check({tag, "_c"}, 16'(c), 16'(ec));
        check({tag, "_flg"}, 16'(flags()), 16'(ef));
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; op = '0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("rst_rdy", 16'(in_ready), 16'd0);
        check("rst_vld", 16'(out_valid), 16'd0);
        check("rst_c", 16'(c), 16'd0);
        check("rst_flg", 16'(flags()), 16'd0);
        rst = 1'b0;
        #1;
        check("post_rst_rdy", 16'(in_ready), 16'd1);

        // Single-cycle ops, back-to-back with out_ready held high
        do_op("add_ff_01", 3'd0, 8'hFF, 8'h01); check_res("add_ff_01", 8'h00, 4'b1010);
        do_op("add_7f_01", 3'd0, 8'h7F, 8'h01); check_res("add_7f_01", 8'h80, 4'b0101);
        do_op("sub_80_01", 3'd1, 8'h80, 8'h01); check_res("sub_80_01", 8'h7F, 4'b0001);
        do_op("sub_03_05", 3'd1, 8'h03, 8'h05); check_res("sub_03_05", 8'hFE, 4'b0110);

        // MUL 0x10*0x11 = 0x110; in_valid held high throughout must be ignored
        do_op("mul_10_11", 3'd7, 8'h10, 8'h11);
        in_valid = 1'b1; op = 3'd0; a = 8'h01; b = 8'h01;
        check("mul_acc_vld", 16'(out_valid), 16'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("mul_wait%0d_vld", i), 16'(out_valid), 16'd0);
            check($sformatf("mul_wait%0d_rdy", i), 16'(in_ready), 16'd0);
        end
        tick();
        in_valid = 1'b0;
        check_res("mul_10_11", 8'h10, 4'b0010);

        do_op("mul_0f_0f", 3'd7, 8'h0F, 8'h0F);
        for (int i = 1; i < 8; i++) tick();
        check("mul_0f_early", 16'(out_valid), 16'd0);
        tick();
        check_res("mul_0f_0f", 8'hE1, 4'b0100);

        do_op("shl_81_1", 3'd5, 8'h81, 8'h01); check_res("shl_81_1", 8'h02, 4'b0010);
        do_op("shr_81_8", 3'd6, 8'h81, 8'h08); check_res("shr_81_8", 8'h81, 4'b0100);
        do_op("shr_81_3", 3'd6, 8'h81, 8'h03); check_res("shr_81_3", 8'h10, 4'b0000);
        do_op("and_f0_0f", 3'd2, 8'hF0, 8'h0F); check_res("and_f0_0f", 8'h00, 4'b1000);

        // Backpressure: result must hold, nothing accepted
        do_op("xor_5a_0f", 3'd4, 8'h5A, 8'h0F); check_res("xor_5a_0f", 8'h55, 4'b0000);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op = 3'(i); a = 8'hA0 + 8'(i); b = 8'h33;
            #1;
            check($sformatf("bp%0d_rdy", i), 16'(in_ready), 16'd0);
            tick();
            check_res($sformatf("bp%0d", i), 8'h55, 4'b0000);
        end
        out_ready = 1'b1;
        do_op("or_30_03", 3'd3, 8'h30, 8'h03); check_res("or_30_03", 8'h33, 4'b0000);
        tick();
        check("drain_vld", 16'(out_valid), 16'd0);

        // Reset in the middle of a multiply aborts it
        do_op("mul_abort", 3'd7, 8'h03, 8'h05);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        check("abort_vld", 16'(out_valid), 16'd0);
        check("abort_c", 16'(c), 16'd0);
        check("abort_flg", 16'(flags()), 16'd0);
        check("abort_rdy", 16'(in_ready), 16'd0);
        rst = 1'b0;
        #1;
        check("abort_rdy2", 16'(in_ready), 16'd1);
        for (int i = 0; i < 10; i++) tick();
        check("abort_no_res", 16'(out_valid), 16'd0);
        do_op("add_2_3", 3'd0, 8'h02, 8'h03); check_res("add_2_3", 8'h05, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
